// File: rtl/mp_input_buffer.sv
// mp_input_buffer: multi-packet router input buffer with flit FIFO, route FIFO and VA/SA read-side FSM
package mp_input_buffer_pkg;
  localparam int DATA_W = 16;
  localparam int VC_NUM = 4;
  localparam int VC_SIZE = $clog2(VC_NUM);
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef struct packed {
    flit_label_t flit_label;
    logic [DATA_W-1:0] data;
  } flit_novc_t;
  typedef struct packed {
    flit_label_t flit_label;
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module mp_input_buffer
  import mp_input_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int MAX_PACKETS = 2,
  parameter int ON_OFF_MARGIN = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  flit_novc_t                         data_i,
  input  logic                               write_i,
  input  port_t                              out_port_i,
  input  logic                               read_i,
  input  logic [VC_SIZE-1:0]                 vc_new_i,
  input  logic                               vc_valid_i,
  output flit_t                              data_o,
  output port_t                              out_port_o,
  output logic [VC_SIZE-1:0]                 downstream_vc_o,
  output logic                               vc_request_o,
  output logic                               switch_request_o,
  output logic                               vc_allocatable_o,
  output logic                               error_o,
  output logic                               is_full_o,
  output logic                               is_empty_o,
  output logic                               on_off_o,
  output logic [$clog2(MAX_PACKETS+1)-1:0]   packets_o
);
  localparam int AW = BUFFER_SIZE > 1 ? $clog2(BUFFER_SIZE) : 1;
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int RW = MAX_PACKETS > 1 ? $clog2(MAX_PACKETS) : 1;
  localparam int PW = $clog2(MAX_PACKETS + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VA = 2'd1;
  localparam logic [1:0] SA = 2'd2;

  flit_novc_t mem [BUFFER_SIZE];
  port_t route_mem [MAX_PACKETS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [RW-1:0] route_wr, route_rd;
  logic [PW-1:0] route_cnt, route_cnt_next;
  logic [1:0] state, state_next;
  logic open;
  logic is_head, wr_ok, rd_ok, head_push, tail_pop, illegal, err;
  flit_novc_t front;

  assign front = mem[rd_ptr];
  assign is_full_o = count == CW'(BUFFER_SIZE);
  assign is_empty_o = count == '0;
  assign is_head = data_i.flit_label inside {HEAD, HEADTAIL};
  // Head writes need a closed packet and a free route slot; body/tail writes need an open packet.
  assign wr_ok = write_i && !is_full_o && (is_head ? !open && route_cnt < PW'(MAX_PACKETS) : open);
  assign head_push = wr_ok && is_head;
  assign rd_ok = read_i && state == SA && !is_empty_o;
  assign tail_pop = rd_ok && front.flit_label inside {TAIL, HEADTAIL};
  assign illegal = !(state inside {IDLE, VA, SA});
  assign err = (write_i && !wr_ok) || (read_i && !rd_ok) || (vc_valid_i && state != VA);
  assign count_next = count + CW'(wr_ok) - CW'(rd_ok);
  assign route_cnt_next = route_cnt + PW'(head_push) - PW'(tail_pop);
  assign vc_request_o = state == VA;
  assign switch_request_o = state == SA && !is_empty_o;
  assign out_port_o = route_cnt != '0 ? route_mem[route_rd] : LOCAL;
  assign packets_o = route_cnt;
  assign data_o = {front.flit_label, downstream_vc_o, front.data};
  // A finished packet goes straight to VA when another route is already waiting behind it.
  assign state_next = illegal ? IDLE :
                      state == IDLE ? (route_cnt != '0 ? VA : IDLE) :
                      state == VA ? (vc_valid_i ? SA : VA) :
                      tail_pop ? (route_cnt_next != '0 ? VA : IDLE) : SA;

  // Flit and route storage; contents need no reset because the counters qualify them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_i;
    if (head_push) route_mem[route_wr] <= out_port_i;
  end

  // Pointers, counters, packet-open flag, FSM and registered status/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      open <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      route_wr <= '0;
      route_rd <= '0;
      route_cnt <= '0;
      downstream_vc_o <= '0;
      vc_allocatable_o <= 1'b0;
      error_o <= 1'b0;
      on_off_o <= 1'b1;
    end else begin
      state <= state_next;
      if (wr_ok && data_i.flit_label == HEAD) open <= 1'b1;
      if (wr_ok && data_i.flit_label == TAIL) open <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (head_push) route_wr <= route_wr == RW'(MAX_PACKETS - 1) ? '0 : route_wr + 1'b1;
      if (tail_pop) route_rd <= route_rd == RW'(MAX_PACKETS - 1) ? '0 : route_rd + 1'b1;
      route_cnt <= route_cnt_next;
      if (state == VA && vc_valid_i) downstream_vc_o <= vc_new_i;
      vc_allocatable_o <= tail_pop || illegal;
      error_o <= err || illegal;
      on_off_o <= (BUFFER_SIZE - int'(count_next)) > ON_OFF_MARGIN;
    end
  end
endmodule

// File: tb/tb_mp_input_buffer.sv
// tb_mp_input_buffer: directed scenarios plus random traffic checked against a queue-based model
module tb_mp_input_buffer;
  import mp_input_buffer_pkg::*;
  localparam int BS = 4;
  localparam int MP = 2;
  localparam int MG = 2;
  localparam int IDLE_S = 0;
  localparam int VA_S = 1;
  localparam int SA_S = 2;

  logic clk = 1'b0;
  logic rst;
  flit_novc_t data_i;
  logic write_i, read_i, vc_valid_i;
  port_t out_port_i;
  logic [VC_SIZE-1:0] vc_new_i;
  flit_t data_o;
  port_t out_port_o;
  logic [VC_SIZE-1:0] downstream_vc_o;
  logic vc_request_o, switch_request_o, vc_allocatable_o, error_o, is_full_o, is_empty_o, on_off_o;
  logic [1:0] packets_o;

  int checks = 0;
  int errors = 0;

  flit_novc_t flit_q[$];
  port_t route_q[$];
  int m_state;
  logic m_open, m_alloc, m_err, m_onoff;
  logic [VC_SIZE-1:0] m_dvc;

  always #5 clk = ~clk;

  mp_input_buffer #(.BUFFER_SIZE(BS), .MAX_PACKETS(MP), .ON_OFF_MARGIN(MG)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .out_port_i(out_port_i),
    .read_i(read_i), .vc_new_i(vc_new_i), .vc_valid_i(vc_valid_i), .data_o(data_o),
    .out_port_o(out_port_o), .downstream_vc_o(downstream_vc_o), .vc_request_o(vc_request_o),
    .switch_request_o(switch_request_o), .vc_allocatable_o(vc_allocatable_o), .error_o(error_o),
    .is_full_o(is_full_o), .is_empty_o(is_empty_o), .on_off_o(on_off_o), .packets_o(packets_o)
  );

  function automatic void model_reset();
    flit_q.delete();
    route_q.delete();
    m_state = IDLE_S;
    m_open = 1'b0;
    m_dvc = '0;
    m_alloc = 1'b0;
    m_err = 1'b0;
    m_onoff = 1'b1;
  endfunction

  task automatic cycle(input logic w, input flit_label_t l, input logic [DATA_W-1:0] d, input port_t p,
                       input logic r, input logic vv, input logic [VC_SIZE-1:0] vc);
    logic head, acc, rdok, tail;
    int nxt;
    write_i = w;
    data_i = '{flit_label: l, data: d};
    out_port_i = p;
    read_i = r;
    vc_valid_i = vv;
    vc_new_i = vc;
    head = l inside {HEAD, HEADTAIL};
    acc = w && flit_q.size() < BS && (head ? !m_open && route_q.size() < MP : m_open);
    rdok = r && m_state == SA_S && flit_q.size() > 0;
    tail = rdok && (flit_q[0].flit_label inside {TAIL, HEADTAIL});
    nxt = m_state;
    if (m_state == IDLE_S && route_q.size() > 0) nxt = VA_S;
    if (m_state == VA_S && vv) begin
      nxt = SA_S;
      m_dvc = vc;
    end
    if (tail) nxt = (route_q.size() - 1 + int'(acc && head)) > 0 ? VA_S : IDLE_S;
    m_err = (w && !acc) || (r && !rdok) || (vv && m_state != VA_S);
    m_alloc = tail;
    if (rdok) void'(flit_q.pop_front());
    if (tail) void'(route_q.pop_front());
    if (acc) begin
      flit_q.push_back(data_i);
      if (head) route_q.push_back(p);
      if (l == HEAD) m_open = 1'b1;
      if (l == TAIL) m_open = 1'b0;
    end
    m_state = nxt;
    m_onoff = (BS - flit_q.size()) > MG;
    @(posedge clk);
    #1;
    write_i = 1'b0;
    read_i = 1'b0;
    vc_valid_i = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, BODY, '0, LOCAL, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(input flit_label_t l, input logic [DATA_W-1:0] d, input port_t p);
    cycle(1'b1, l, d, p, 1'b0, 1'b0, '0);
  endtask

  task automatic rd();
    cycle(1'b0, BODY, '0, LOCAL, 1'b1, 1'b0, '0);
  endtask

  task automatic grant(input logic [VC_SIZE-1:0] vc);
    cycle(1'b0, BODY, '0, LOCAL, 1'b0, 1'b1, vc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({out_port_o, downstream_vc_o, vc_allocatable_o, error_o, packets_o, is_empty_o, is_full_o, on_off_o, vc_request_o, switch_request_o}
        !== {LOCAL, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", {out_port_o, downstream_vc_o, vc_allocatable_o, error_o, packets_o, is_empty_o, is_full_o, on_off_o, vc_request_o, switch_request_o},
               {LOCAL, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    checks++;
    if ({error_o, is_empty_o, on_off_o, vc_request_o, packets_o} !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", {error_o, is_empty_o, on_off_o, vc_request_o, packets_o}, 6'b011000);
    end
  endtask

  task automatic test_single_packet();
    flit_label_t labs[3] = '{HEAD, BODY, TAIL};
    logic [DATA_W-1:0] dats[3] = '{16'h1111, 16'h2222, 16'h3333};
    flit_t e;
    do_reset();
    wr(HEAD, dats[0], EAST);
    checks++;
    if ({packets_o, out_port_o, vc_request_o} !== {2'd1, EAST, 1'b0}) begin
      errors++;
      $display("FAIL single_head got=%h exp=%h", {packets_o, out_port_o, vc_request_o}, {2'd1, EAST, 1'b0});
    end
    wr(BODY, dats[1], EAST);
    checks++;
    if (vc_request_o !== 1'b1) begin
      errors++;
      $display("FAIL single_va got=%b exp=1", vc_request_o);
    end
    cycle(1'b1, TAIL, dats[2], EAST, 1'b0, 1'b1, 2'd1);
    checks++;
    if ({switch_request_o, downstream_vc_o, error_o} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_sa got=%b exp=%b", {switch_request_o, downstream_vc_o, error_o}, 4'b1010);
    end
    for (int i = 0; i < 3; i++) begin
      e = '{flit_label: labs[i], vc_id: 2'd1, data: dats[i]};
      checks++;
      if (data_o !== e) begin
        errors++;
        $display("FAIL single_data%0d got=%h exp=%h", i, data_o, e);
      end
      rd();
      checks++;
      if (vc_allocatable_o !== (i == 2)) begin
        errors++;
        $display("FAIL single_alloc%0d got=%b exp=%b", i, vc_allocatable_o, i == 2);
      end
    end
    checks++;
    if ({vc_request_o, switch_request_o, packets_o, is_empty_o, out_port_o} !== {1'b0, 1'b0, 2'd0, 1'b1, LOCAL}) begin
      errors++;
      $display("FAIL single_done got=%h exp=%h", {vc_request_o, switch_request_o, packets_o, is_empty_o, out_port_o}, {1'b0, 1'b0, 2'd0, 1'b1, LOCAL});
    end
    idle();
    checks++;
    if ({vc_allocatable_o, vc_request_o} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got=%b exp=00", {vc_allocatable_o, vc_request_o});
    end
  endtask

  task automatic test_back_to_back();
    flit_t e;
    do_reset();
    wr(HEADTAIL, 16'h00AA, NORTH);
    wr(HEADTAIL, 16'h00BB, SOUTH);
    checks++;
    if ({packets_o, out_port_o, vc_request_o} !== {2'd2, NORTH, 1'b1}) begin
      errors++;
      $display("FAIL b2b_two got=%h exp=%h", {packets_o, out_port_o, vc_request_o}, {2'd2, NORTH, 1'b1});
    end
    grant(2'd2);
    rd();
    checks++;
    if ({vc_request_o, out_port_o, packets_o, vc_allocatable_o} !== {1'b1, SOUTH, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_direct_va got=%h exp=%h", {vc_request_o, out_port_o, packets_o, vc_allocatable_o}, {1'b1, SOUTH, 2'd1, 1'b1});
    end
    grant(2'd3);
    e = '{flit_label: HEADTAIL, vc_id: 2'd3, data: 16'h00BB};
    checks++;
    if (data_o !== e) begin
      errors++;
      $display("FAIL b2b_second_data got=%h exp=%h", data_o, e);
    end
    rd();
    checks++;
    if ({packets_o, vc_request_o, switch_request_o, out_port_o} !== {2'd0, 1'b0, 1'b0, LOCAL}) begin
      errors++;
      $display("FAIL b2b_drain got=%h exp=%h", {packets_o, vc_request_o, switch_request_o, out_port_o}, {2'd0, 1'b0, 1'b0, LOCAL});
    end
  endtask

  task automatic test_packet_limit();
    do_reset();
    wr(HEADTAIL, 16'h0001, NORTH);
    wr(HEADTAIL, 16'h0002, SOUTH);
    wr(HEAD, 16'h0003, EAST);
    checks++;
    if ({error_o, packets_o, out_port_o} !== {1'b1, 2'd2, NORTH}) begin
      errors++;
      $display("FAIL limit_drop got=%h exp=%h", {error_o, packets_o, out_port_o}, {1'b1, 2'd2, NORTH});
    end
    wr(BODY, 16'h0004, EAST);
    checks++;
    if ({error_o, packets_o} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL limit_not_open got=%b exp=110", {error_o, packets_o});
    end
    idle();
    checks++;
    if ({error_o, on_off_o, is_full_o} !== 3'b000) begin
      errors++;
      $display("FAIL limit_occupancy got=%b exp=000", {error_o, on_off_o, is_full_o});
    end
  endtask

  task automatic test_full_read();
    do_reset();
    wr(HEAD, 16'h0010, EAST);
    wr(BODY, 16'h0011, EAST);
    cycle(1'b1, BODY, 16'h0012, EAST, 1'b0, 1'b1, 2'd0);
    wr(BODY, 16'h0013, EAST);
    checks++;
    if ({is_full_o, on_off_o, error_o, switch_request_o} !== 4'b1001) begin
      errors++;
      $display("FAIL full_fill got=%b exp=1001", {is_full_o, on_off_o, error_o, switch_request_o});
    end
    cycle(1'b1, BODY, 16'h0014, EAST, 1'b1, 1'b0, '0);
    checks++;
    if ({error_o, is_full_o, is_empty_o, on_off_o} !== 4'b1000) begin
      errors++;
      $display("FAIL full_write_read got=%b exp=1000", {error_o, is_full_o, is_empty_o, on_off_o});
    end
    rd();
    checks++;
    if ({error_o, on_off_o} !== 2'b00) begin
      errors++;
      $display("FAIL full_occ2 got=%b exp=00", {error_o, on_off_o});
    end
    rd();
    checks++;
    if ({on_off_o, is_empty_o} !== 2'b10) begin
      errors++;
      $display("FAIL full_occ1 got=%b exp=10", {on_off_o, is_empty_o});
    end
    cycle(1'b1, BODY, 16'h0015, EAST, 1'b1, 1'b0, '0);
    checks++;
    if ({error_o, on_off_o, is_empty_o, data_o.data} !== {3'b010, 16'h0015}) begin
      errors++;
      $display("FAIL full_simul got=%h exp=%h", {error_o, on_off_o, is_empty_o, data_o.data}, {3'b010, 16'h0015});
    end
    rd();
    checks++;
    if ({is_empty_o, on_off_o, switch_request_o} !== 3'b110) begin
      errors++;
      $display("FAIL full_empty got=%b exp=110", {is_empty_o, on_off_o, switch_request_o});
    end
  endtask

  task automatic test_protocol_errors();
    do_reset();
    wr(BODY, 16'h0020, WEST);
    checks++;
    if ({error_o, is_empty_o, packets_o} !== 4'b1100) begin
      errors++;
      $display("FAIL err_body_closed got=%b exp=1100", {error_o, is_empty_o, packets_o});
    end
    idle();
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got=%b exp=0", error_o);
    end
    rd();
    checks++;
    if ({error_o, is_empty_o, vc_request_o} !== 3'b110) begin
      errors++;
      $display("FAIL err_read_idle got=%b exp=110", {error_o, is_empty_o, vc_request_o});
    end
    wr(HEAD, 16'h0021, EAST);
    idle();
    grant(2'd1);
    grant(2'd2);
    checks++;
    if ({error_o, downstream_vc_o, switch_request_o, vc_request_o} !== 5'b10110) begin
      errors++;
      $display("FAIL err_vc_in_sa got=%b exp=10110", {error_o, downstream_vc_o, switch_request_o, vc_request_o});
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    wr(HEAD, 16'h0030, EAST);
    wr(BODY, 16'h0031, EAST);
    grant(2'd3);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({out_port_o, downstream_vc_o, vc_allocatable_o, error_o, packets_o, is_empty_o, is_full_o, on_off_o, switch_request_o}
        !== {LOCAL, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async got=%h exp=%h", {out_port_o, downstream_vc_o, vc_allocatable_o, error_o, packets_o, is_empty_o, is_full_o, on_off_o, switch_request_o},
               {LOCAL, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    checks++;
    if ({error_o, is_empty_o, packets_o, vc_request_o, switch_request_o} !== 6'b010000) begin
      errors++;
      $display("FAIL midrst_release got=%b exp=010000", {error_o, is_empty_o, packets_o, vc_request_o, switch_request_o});
    end
    wr(HEADTAIL, 16'h0032, WEST);
    checks++;
    if ({packets_o, out_port_o, is_empty_o, error_o} !== {2'd1, WEST, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_fresh got=%h exp=%h", {packets_o, out_port_o, is_empty_o, error_o}, {2'd1, WEST, 1'b0, 1'b0});
    end
    idle();
    checks++;
    if (vc_request_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_va got=%b exp=1", vc_request_o);
    end
  endtask

  task automatic test_random();
    logic [13:0] got, exp;
    flit_t e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), flit_label_t'($urandom_range(0, 3)), DATA_W'($urandom),
            port_t'($urandom_range(0, 4)), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            VC_SIZE'($urandom));
      got = {vc_request_o, switch_request_o, out_port_o, downstream_vc_o, packets_o, vc_allocatable_o,
             error_o, is_full_o, is_empty_o, on_off_o};
      exp = {m_state == VA_S, m_state == SA_S && flit_q.size() > 0, route_q.size() > 0 ? route_q[0] : LOCAL,
             m_dvc, 2'(route_q.size()), m_alloc, m_err, flit_q.size() == BS, flit_q.size() == 0, m_onoff};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_status cycle=%0d got=%h exp=%h", n, got, exp);
      end
      if (flit_q.size() > 0) begin
        e = '{flit_label: flit_q[0].flit_label, vc_id: m_dvc, data: flit_q[0].data};
        checks++;
        if (data_o !== e) begin
          errors++;
          $display("FAIL random_data cycle=%0d got=%h exp=%h", n, data_o, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    write_i = 1'b0;
    read_i = 1'b0;
    vc_valid_i = 1'b0;
    vc_new_i = '0;
    out_port_i = LOCAL;
    data_i = '0;
    model_reset();
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_packet_limit();
    test_full_read();
    test_protocol_errors();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_input_buffer.md
MP_INPUT_BUFFER -- requirements
Module: mp_input_buffer

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 8: flit FIFO depth in flits, power of two, at least 2.
REQ-002 The block SHALL have parameter MAX_PACKETS, default 2: number of packets that may be resident at once, at least 1.
REQ-003 The block SHALL have parameter ON_OFF_MARGIN, default 2: on_off_o deasserts when free flit slots are at or below this value.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 data_i  in  flit_novc_t  incoming flit (label and data).
REQ-007 write_i  in  1  upstream write strobe.
REQ-008 out_port_i  in  port_t  route for the flit on data_i; sampled only with a head write.
REQ-009 read_i  in  1  switch grant; pop one flit.
REQ-010 vc_new_i  in  VC_SIZE  allocated downstream VC.
REQ-011 vc_valid_i  in  1  vc_new_i valid.
REQ-012 data_o  out  flit_t  front flit with vc_id = downstream_vc_o; combinational.
REQ-013 out_port_o  out  port_t  route of the front packet.
REQ-014 downstream_vc_o, vc_request_o, switch_request_o, vc_allocatable_o, error_o  out  VC_SIZE/1/1/1/1  same meaning as in the single-packet input buffer.
REQ-015 is_full_o, is_empty_o, on_off_o  out  1  flit FIFO status.
REQ-016 packets_o  out  clog2(MAX_PACKETS+1)  number of resident packets, counting any packet whose head has been accepted and whose tail has not been popped.

Function
REQ-017 Write side: a one-bit open flag SHALL track whether a packet is being written. An accepted HEAD sets it. An accepted TAIL clears it. HEADTAIL leaves it clear.
REQ-018 A HEAD or HEADTAIL write SHALL be accepted when all of the following hold: open is clear, the FIFO is not full, and packets_o < MAX_PACKETS. It SHALL be accepted in any read-side state.
REQ-019 On an accepted HEAD or HEADTAIL write, out_port_i SHALL be pushed into a route FIFO of depth MAX_PACKETS.
REQ-020 A BODY or TAIL write SHALL be accepted only when open is set and the FIFO is not full.
REQ-021 Full and packet-limit checks SHALL use start-of-cycle state, with no read-through. A write while full is rejected even when read_i is asserted in the same cycle.
REQ-022 Rejected writes SHALL be dropped, and no state changes.
REQ-023 Read-side FSM, IDLE to VA: IDLE SHALL move to VA on the next edge when the route FIFO is non-empty.
REQ-024 Read-side FSM, VA: vc_request_o = 1. When vc_valid_i is high, the block SHALL latch vc_new_i into downstream_vc_o and move to SA.
REQ-025 Read-side FSM, SA: switch_request_o = ~is_empty_o, and read_i pops one flit.
REQ-026 Read-side FSM, end of packet: popping a TAIL or HEADTAIL SHALL pop the route FIFO, pulse vc_allocatable_o for one cycle on the next edge, and move to VA if another route is queued behind it, else to IDLE.
REQ-027 Read-side FSM, illegal encoding: the block SHALL go to IDLE, pulse error_o, and pulse vc_allocatable_o.
REQ-028 vc_request_o and switch_request_o SHALL be combinational from state. vc_request_o is 0 outside VA; switch_request_o is 0 outside SA.
REQ-029 on_off_o SHALL equal (BUFFER_SIZE - occupancy) > ON_OFF_MARGIN, registered.
REQ-030 error_o SHALL be a registered one-cycle pulse for any of: a rejected write, read_i outside SA, read_i while empty, or vc_valid_i outside VA.
REQ-031 A read_i outside SA or while empty SHALL NOT pop.
REQ-032 packets_o SHALL increment on an accepted head and decrement on a tail pop. When both occur in the same cycle it is unchanged.
REQ-033 Read and write pointers SHALL wrap modulo BUFFER_SIZE. A simultaneous accepted write and pop SHALL leave occupancy unchanged.

Reset
REQ-034 On rst high, immediately and independent of clk, the block SHALL reset as follows:
- FSM = IDLE, FIFOs empty, open = 0.
- out_port_o = LOCAL, downstream_vc_o = 0.
- vc_allocatable_o = 0, error_o = 0, packets_o = 0.
- is_empty_o = 1, is_full_o = 0, on_off_o = 1.
REQ-035 A reset mid-packet SHALL discard all resident flits and routes, and produce no error pulse.

Verification
REQ-036 Single packet: write HEAD(port=EAST), BODY, TAIL; assert vc_valid_i with vc=1 in the first VA cycle; read three times. Required response:
- out_port_o = EAST;
- data_o.vc_id = 1 on every flit;
- vc_allocatable_o pulses once after the TAIL pop;
- FSM returns to IDLE and packets_o returns to 0.
REQ-037 Back-to-back packets: write HEADTAIL(NORTH) then HEADTAIL(SOUTH) before any VA grant. Required response:
- packets_o = 2;
- after the first pop the FSM goes directly to VA with out_port_o = SOUTH, without passing through IDLE.
REQ-038 Packet limit (MAX_PACKETS=2): write a third HEAD while two packets are resident. Required response: the write is dropped, error_o pulses, and packets_o stays 2.
REQ-039 Full with read (BUFFER_SIZE=4): fill 4 flits, then write and read in the same cycle. Required response:
- the write is rejected and error_o pulses;
- occupancy becomes 3;
- on_off_o = 0 at occupancy 2 or more, and returns to 1 at occupancy 1.
REQ-040 Protocol errors, each of which SHALL produce one error_o pulse and change no state:
- BODY written while open = 0;
- read_i in IDLE;
- vc_valid_i in SA.
REQ-041 Reset mid-packet: assert rst after HEAD+BODY have been written. Required response: all outputs hold their reset values while rst is high and after it is released, and a fresh HEADTAIL is then accepted normally.
